board_io_param: RTL and testbench



---
 rtl/board_io_param_pkg.sv | 50 +++++
 rtl/if_io.sv | 15 +
 rtl/board_io_param_key_debounce.sv | 62 ++++++
 rtl/board_io_param.sv | 150 +++++++++++++++
 tb/tb_board_io_param.sv | 251 +++++++++++++++++++++++++
 5 files changed

// File: rtl/board_io_param_pkg.sv
// board_io_param_pkg
// Address map and shared types for the evaluation-board I/O slave on the J1 I/O bus.
// Contents:
//   IO_* localparams : register addresses (HEX digits live at IO_HEX_BASE + i)
//   N_HEX_MAX        : largest number of seven-segment digits the map can address
//   reg_sel_e        : decoded register selection
//   decode_addr()    : bus address -> reg_sel_e
package board_io_param_pkg;

    localparam int IO_W      = 16;
    localparam int N_HEX_MAX = 16;

    localparam logic [IO_W-1:0] IO_LEDG     = 16'h0001;
    localparam logic [IO_W-1:0] IO_LEDR     = 16'h0002;
    localparam logic [IO_W-1:0] IO_KEY      = 16'h0003;
    localparam logic [IO_W-1:0] IO_SW       = 16'h0004;
    localparam logic [IO_W-1:0] IO_KEYEV    = 16'h0005;
    // HEX_BASE is aligned to N_HEX_MAX so the digit index is simply addr[3:0];
    // the old HEX0..HEX3 addresses are HEX_BASE+0..3.
    localparam logic [IO_W-1:0] IO_HEX_BASE = 16'h0010;

    typedef enum logic [2:0] {
        SEL_NONE,
        SEL_KEY,
        SEL_SW,
        SEL_KEYEV,
        SEL_LEDG,
        SEL_LEDR,
        SEL_HEX
    } reg_sel_e;

    function automatic reg_sel_e decode_addr(input logic [IO_W-1:0] a);
        reg_sel_e sel;
        sel = SEL_NONE;
        if (a[IO_W-1:4] == IO_HEX_BASE[IO_W-1:4]) begin
            sel = SEL_HEX;
        end else begin
            case (a)
                IO_LEDG:  sel = SEL_LEDG;
                IO_LEDR:  sel = SEL_LEDR;
                IO_KEY:   sel = SEL_KEY;
                IO_SW:    sel = SEL_SW;
                IO_KEYEV: sel = SEL_KEYEV;
                default:  sel = SEL_NONE;
            endcase
        end
        return sel;
    endfunction

endpackage

// File: rtl/if_io.sv
// if_io
// J1 I/O bus. The CPU drives rd/wr/addr/dout; every slave drives din and the
// system ORs all slave din values together, so an unselected slave returns 0.
// Handshake: no valid/ready. A write takes effect on the clock edge where wr=1;
// a read is combinational, din is valid in the same cycle rd=1 is presented.
interface if_io;
    logic        rd;
    logic        wr;
    logic [15:0] addr;
    logic [15:0] dout;
    logic [15:0] din;

    modport slave  (input rd, input wr, input addr, input dout, output din);
    modport master (output rd, output wr, output addr, output dout, input din);
endinterface

// File: rtl/board_io_param_key_debounce.sv
// key_debounce
// One push button: synchroniser chain, stability counter, debounced level and
// a press indication.
// Ports:
//   clk, reset : clock, synchronous active-high reset
//   key        : raw asynchronous pin (active-low)
//   level      : debounced level, pin polarity (1 = released)
//   press      : high during the cycle whose closing edge moves level 1->0
module key_debounce #(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 50000
) (
    input  logic clk,
    input  logic reset,
    input  logic key,
    output logic level,
    output logic press
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [CW-1:0]          cnt_q;
    logic                   stable_q;
    logic                   synced;
    logic                   mismatch;
    logic                   accept;

    assign synced   = sync_q[SYNC_STAGES-1];
    assign mismatch = (synced != stable_q);
    assign accept   = mismatch && (cnt_q == CNT_LAST);

    // Combinational so the event register sets on the same edge level falls.
    assign press = accept && !synced;
    assign level = stable_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q <= '1;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], key};
        end
    end

    // Any cycle back at the stable level clears the count, so a bounce
    // restarts the full stable-time.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q    <= '0;
            stable_q <= 1'b1;
        end else if (!mismatch) begin
            cnt_q <= '0;
        end else if (accept) begin
            cnt_q    <= '0;
            stable_q <= synced;
        end else begin
            cnt_q <= cnt_q + CW'(1);
        end
    end

endmodule

// File: rtl/board_io_param.sv
// board_io_param
// Parametrised evaluation-board I/O slave on the J1 I/O bus.
// Ports:
//   clk, reset : clock, synchronous active-high reset
//   key        : N_KEY push buttons, asynchronous, active-low
//   sw         : N_SW toggle switches, asynchronous
//   hex        : N_HEX seven-segment digits, active-low segments
//   ledg, ledr : green / red LEDs
//   io         : J1 I/O bus slave (rd, wr, addr, dout in; din out)
// Registers: LEDG, LEDR, HEX_BASE+i (write/read), KEY, SW (read),
// KEYEV (sticky press events, cleared by reading).
module board_io_param
    import board_io_param_pkg::*;
#(
    parameter int N_KEY           = 4,
    parameter int N_SW            = 10,
    parameter int N_LEDG          = 8,
    parameter int N_LEDR          = 10,
    parameter int N_HEX           = 4,
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 50000
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [N_KEY-1:0]       key,
    input  logic [N_SW-1:0]        sw,
    output logic [0:N_HEX-1][6:0]  hex,
    output logic [N_LEDG-1:0]      ledg,
    output logic [N_LEDR-1:0]      ledr,
    if_io.slave                    io
);

    if (N_KEY < 1 || N_KEY > 16) begin : g_bad_n_key
        $error("N_KEY must be in 1..16");
    end
    if (N_SW < 1 || N_SW > 16) begin : g_bad_n_sw
        $error("N_SW must be in 1..16");
    end
    if (N_LEDG < 1 || N_LEDG > 16) begin : g_bad_n_ledg
        $error("N_LEDG must be in 1..16");
    end
    if (N_LEDR < 1 || N_LEDR > 16) begin : g_bad_n_ledr
        $error("N_LEDR must be in 1..16");
    end
    if (N_HEX < 1 || N_HEX > N_HEX_MAX) begin : g_bad_n_hex
        $error("N_HEX must be in 1..16");
    end
    if (SYNC_STAGES < 2) begin : g_bad_sync
        $error("SYNC_STAGES must be >= 2");
    end
    if (DEBOUNCE_CYCLES < 2) begin : g_bad_debounce
        $error("DEBOUNCE_CYCLES must be >= 2");
    end

    logic [N_KEY-1:0] key_level;
    logic [N_KEY-1:0] key_press;
    logic [N_SW-1:0]  sw_synced;
    logic [N_KEY-1:0] keyev_q;
    logic [N_KEY-1:0] keyev_clr;
    logic [15:0]      din_c;
    logic [3:0]       hex_idx;
    reg_sel_e         sel;

    assign sel     = decode_addr(io.addr);
    assign hex_idx = io.addr[3:0];

    for (genvar i = 0; i < N_KEY; i++) begin : g_key
        key_debounce #(
            .SYNC_STAGES     (SYNC_STAGES),
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
        ) u_debounce (
            .clk   (clk),
            .reset (reset),
            .key   (key[i]),
            .level (key_level[i]),
            .press (key_press[i])
        );
    end

    for (genvar b = 0; b < N_SW; b++) begin : g_sw
        logic [SYNC_STAGES-1:0] q;
        always_ff @(posedge clk) begin
            if (reset) begin
                q <= '0;
            end else begin
                q <= {q[SYNC_STAGES-2:0], sw[b]};
            end
        end
        assign sw_synced[b] = q[SYNC_STAGES-1];
    end

    // Output registers. HEX digits beyond N_HEX simply match nothing.
    always_ff @(posedge clk) begin
        if (reset) begin
            ledg <= '0;
            ledr <= '0;
            hex  <= '1;
        end else if (io.wr) begin
            case (sel)
                SEL_LEDG: ledg <= io.dout[N_LEDG-1:0];
                SEL_LEDR: ledr <= io.dout[N_LEDR-1:0];
                SEL_HEX: begin
                    for (int i = 0; i < N_HEX; i++) begin
                        if (hex_idx == 4'(i)) begin
                            hex[i] <= ~io.dout[6:0];
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // Only the bits actually returned by this read are cleared; a press landing
    // on the same edge is ORed in afterwards so it is never lost.
    assign keyev_clr = (io.rd && sel == SEL_KEYEV) ? keyev_q : '0;

    always_ff @(posedge clk) begin
        if (reset) begin
            keyev_q <= '0;
        end else begin
            keyev_q <= (keyev_q & ~keyev_clr) | key_press;
        end
    end

    // Read mux; register state is read before any same-cycle write lands.
    always_comb begin
        din_c = '0;
        if (io.rd) begin
            case (sel)
                SEL_KEY:   din_c[N_KEY-1:0]  = key_level;
                SEL_SW:    din_c[N_SW-1:0]   = sw_synced;
                SEL_KEYEV: din_c[N_KEY-1:0]  = keyev_q;
                SEL_LEDG:  din_c[N_LEDG-1:0] = ledg;
                SEL_LEDR:  din_c[N_LEDR-1:0] = ledr;
                SEL_HEX: begin
                    for (int i = 0; i < N_HEX; i++) begin
                        if (hex_idx == 4'(i)) begin
                            din_c[6:0] = ~hex[i];
                        end
                    end
                end
                default: din_c = '0;
            endcase
        end
    end

    assign io.din = din_c;

endmodule

// File: tb/tb_board_io_param.sv
// tb_board_io_param
// Directed bench for board_io_param with DEBOUNCE_CYCLES=8, SYNC_STAGES=2.
module tb_board_io_param;
    import board_io_param_pkg::*;

    localparam logic [27:0] HEX_INIT = {4{7'h7F}};
    localparam logic [27:0] HEX_W2   = {7'h7F, 7'h7F, 7'h3F, 7'h7F};

    logic             clk;
    logic             reset;
    logic [3:0]       key;
    logic [9:0]       sw;
    logic [0:3][6:0]  hex;
    logic [7:0]       ledg;
    logic [9:0]       ledr;

    if_io io_bus ();

    board_io_param #(
        .N_KEY           (4),
        .N_SW            (10),
        .N_LEDG          (8),
        .N_LEDR          (10),
        .N_HEX           (4),
        .SYNC_STAGES     (2),
        .DEBOUNCE_CYCLES (8)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .key   (key),
        .sw    (sw),
        .hex   (hex),
        .ledg  (ledg),
        .ledr  (ledr),
        .io    (io_bus.slave)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    // ---------------- scoreboard ----------------
    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Combinational read that releases rd before the next edge (no side effects).
    task automatic peek(input logic [15:0] a, output logic [15:0] d);
        io_bus.rd   = 1'b1;
        io_bus.addr = a;
        #1;
        d = io_bus.din;
        io_bus.rd   = 1'b0;
        io_bus.addr = 16'h0;
    endtask

    task automatic peek_check(input string name, input logic [15:0] a, input logic [15:0] exp);
        logic [15:0] d;
        peek(a, d);
        check(name, {16'h0, d}, {16'h0, exp});
    endtask

    // Read held across a clock edge, so KEYEV clearing takes effect.
    task automatic read_edge(input string name, input logic [15:0] a, input logic [15:0] exp);
        io_bus.rd   = 1'b1;
        io_bus.addr = a;
        #1;
        check(name, {16'h0, io_bus.din}, {16'h0, exp});
        tick();
        io_bus.rd   = 1'b0;
        io_bus.addr = 16'h0;
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic        rd;
        logic        wr;
        logic [15:0] addr;
        logic [15:0] data;
        logic [15:0] exp_din;
        logic [7:0]  exp_ledg;
        logic [9:0]  exp_ledr;
        logic [27:0] exp_hex;
    } vec_t;

    localparam int N_VEC = 20;
    vec_t vecs [N_VEC];

    initial begin
        logic [15:0] hx;
        hx = IO_HEX_BASE;

        //           rd    wr    addr        data      din       ledg    ledr     hex
        vecs[0]  = '{1'b1, 1'b0, IO_KEY,     16'h0000, 16'h000F, 8'h00, 10'h000, HEX_INIT};
        vecs[1]  = '{1'b1, 1'b0, IO_SW,      16'h0000, 16'h02A5, 8'h00, 10'h000, HEX_INIT};
        vecs[2]  = '{1'b1, 1'b0, IO_LEDG,    16'h0000, 16'h0000, 8'h00, 10'h000, HEX_INIT};
        vecs[3]  = '{1'b1, 1'b0, IO_LEDR,    16'h0000, 16'h0000, 8'h00, 10'h000, HEX_INIT};
        vecs[4]  = '{1'b1, 1'b0, hx,         16'h0000, 16'h0000, 8'h00, 10'h000, HEX_INIT};
        vecs[5]  = '{1'b0, 1'b1, IO_LEDG,    16'hFFA5, 16'h0000, 8'hA5, 10'h000, HEX_INIT};
        vecs[6]  = '{1'b0, 1'b1, IO_LEDR,    16'h03FF, 16'h0000, 8'hA5, 10'h3FF, HEX_INIT};
        vecs[7]  = '{1'b0, 1'b1, hx + 16'd2, 16'h0040, 16'h0000, 8'hA5, 10'h3FF, HEX_W2};
        vecs[8]  = '{1'b1, 1'b0, IO_LEDG,    16'h0000, 16'h00A5, 8'hA5, 10'h3FF, HEX_W2};
        vecs[9]  = '{1'b1, 1'b0, IO_LEDR,    16'h0000, 16'h03FF, 8'hA5, 10'h3FF, HEX_W2};
        vecs[10] = '{1'b1, 1'b0, hx + 16'd2, 16'h0000, 16'h0040, 8'hA5, 10'h3FF, HEX_W2};
        vecs[11] = '{1'b0, 1'b1, hx + 16'd4, 16'h007F, 16'h0000, 8'hA5, 10'h3FF, HEX_W2};
        vecs[12] = '{1'b1, 1'b0, hx + 16'd4, 16'h0000, 16'h0000, 8'hA5, 10'h3FF, HEX_W2};
        vecs[13] = '{1'b1, 1'b1, IO_LEDG,    16'h0011, 16'h00A5, 8'h11, 10'h3FF, HEX_W2};
        vecs[14] = '{1'b1, 1'b0, IO_LEDG,    16'h0000, 16'h0011, 8'h11, 10'h3FF, HEX_W2};
        vecs[15] = '{1'b1, 1'b0, 16'h00FF,   16'h0000, 16'h0000, 8'h11, 10'h3FF, HEX_W2};
        vecs[16] = '{1'b0, 1'b0, IO_LEDG,    16'h0000, 16'h0000, 8'h11, 10'h3FF, HEX_W2};
        vecs[17] = '{1'b1, 1'b0, IO_KEYEV,   16'h0000, 16'h0000, 8'h11, 10'h3FF, HEX_W2};
        vecs[18] = '{1'b0, 1'b1, IO_KEY,     16'h0000, 16'h0000, 8'h11, 10'h3FF, HEX_W2};
        vecs[19] = '{1'b1, 1'b1, hx + 16'd0, 16'h0008, 16'h0000, 8'h11, 10'h3FF,
                     {7'h77, 7'h7F, 7'h3F, 7'h7F}};
    end

    // ---------------- main sequence ----------------
    initial begin
        reset       = 1'b1;
        key         = 4'hF;
        sw          = 10'h2A5;
        io_bus.rd   = 1'b0;
        io_bus.wr   = 1'b0;
        io_bus.addr = 16'h0;
        io_bus.dout = 16'h0;
        tick();
        tick();
        reset = 1'b0;
        tick();
        tick();
        tick();

        // Table: din checked before the edge, outputs checked after it.
        for (int v = 0; v < N_VEC; v++) begin
            io_bus.rd   = vecs[v].rd;
            io_bus.wr   = vecs[v].wr;
            io_bus.addr = vecs[v].addr;
            io_bus.dout = vecs[v].data;
            #1;
            check($sformatf("vec%0d din", v), {16'h0, io_bus.din}, {16'h0, vecs[v].exp_din});
            tick();
            io_bus.rd = 1'b0;
            io_bus.wr = 1'b0;
            check($sformatf("vec%0d ledg", v), {24'h0, ledg}, {24'h0, vecs[v].exp_ledg});
            check($sformatf("vec%0d ledr", v), {22'h0, ledr}, {22'h0, vecs[v].exp_ledr});
            check($sformatf("vec%0d hex", v), {4'h0, hex}, {4'h0, vecs[v].exp_hex});
        end

        // key[1] press: level change exactly 10 edges after the pin change.
        key = 4'b1101;
        for (int e = 1; e <= 10; e++) begin
            tick();
            if (e == 9) peek_check("key1 edge9 KEY", IO_KEY, 16'h000F);
            if (e == 10) begin
                peek_check("key1 edge10 KEY", IO_KEY, 16'h000D);
                peek_check("key1 KEYEV", IO_KEYEV, 16'h0002);
            end
        end
        read_edge("keyev read", IO_KEYEV, 16'h0002);
        peek_check("keyev after clear", IO_KEYEV, 16'h0000);

        // Release sets no event.
        key = 4'hF;
        repeat (12) tick();
        peek_check("release KEY", IO_KEY, 16'h000F);
        peek_check("release KEYEV", IO_KEYEV, 16'h0000);

        // Bounce on key[0]: low 5, high 1, then low.
        key = 4'b1110;
        repeat (5) tick();
        key = 4'b1111;
        tick();
        key = 4'b1110;
        for (int e = 1; e <= 10; e++) begin
            tick();
            if (e == 9) begin
                peek_check("bounce edge9 KEY", IO_KEY, 16'h000F);
                peek_check("bounce edge9 KEYEV", IO_KEYEV, 16'h0000);
            end
            if (e == 10) begin
                peek_check("bounce edge10 KEY", IO_KEY, 16'h000E);
                peek_check("bounce KEYEV", IO_KEYEV, 16'h0001);
            end
        end

        // key[2] press lands on the KEYEV clearing edge: set wins.
        key = 4'b1010;
        repeat (9) tick();
        read_edge("keyev clr race read", IO_KEYEV, 16'h0001);
        peek_check("keyev clr race after", IO_KEYEV, 16'h0004);
        peek_check("race KEY", IO_KEY, 16'h000A);

        // Switch synchroniser latency.
        sw = 10'h15A;
        tick();
        peek_check("sw edge1", IO_SW, 16'h02A5);
        tick();
        peek_check("sw edge2", IO_SW, 16'h015A);

        // Reset mid-debounce with KEYEV=0x0003.
        key = 4'hF;
        repeat (12) tick();
        read_edge("keyev pre reset clr", IO_KEYEV, 16'h0004);
        key = 4'b1100;
        repeat (10) tick();
        peek_check("pre reset KEYEV", IO_KEYEV, 16'h0003);
        peek_check("pre reset KEY", IO_KEY, 16'h000C);
        key = 4'b0100;
        repeat (5) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        peek_check("post reset KEYEV", IO_KEYEV, 16'h0000);
        peek_check("post reset KEY", IO_KEY, 16'h000F);
        peek_check("unmapped read", 16'h00FF, 16'h0000);
        check("post reset ledg", {24'h0, ledg}, 32'h0);
        check("post reset ledr", {22'h0, ledr}, 32'h0);
        check("post reset hex", {4'h0, hex}, {4'h0, HEX_INIT});
        for (int e = 1; e <= 10; e++) begin
            tick();
            if (e == 9) peek_check("restart edge9 KEY", IO_KEY, 16'h000F);
            if (e == 10) begin
                peek_check("restart edge10 KEY", IO_KEY, 16'h0004);
                peek_check("restart KEYEV", IO_KEYEV, 16'h000B);
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
